data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Memory-stage controller for the core. It takes the `tMemOp` produced by the ALU stage and sequences one load or store at a time onto a single-outstanding request/acknowledge data bus. It generates byte enables, replicates store data and aligns/sign-extends load data. It stalls the pipeline while busy, writes load results back as a `tRegOp`, and flags misaligned, illegal, bus-error and timeout conditions.

## Interface
Parameters:
- pTimeout, 64, number of REQ cycles without `iBusAck` before the transaction is aborted as a timeout; must be ≥2.
- cXLEN, 32 (from corePckg), data/address width.

Ports:
- iClk  in  1  core clock; everything is on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iMemOp  in  tMemOp (74)  read/write/addr/data/opType(funct3)/rdAddr.
- iMemOpDv  in  1  iMemOp valid this cycle.
- iFlush  in  1  discard the current op; suppress any pending load writeback.
- oStall  out  1  controller busy; upstream holds its op.
- oBusReq  out  1  bus request.
- oBusWe  out  1  1 = write.
- oBusAddr  out  32  word-aligned address, {addr[31:2],2'b00}.
- oBusWData  out  32  replicated store data.
- oBusBe  out  4  byte enables.
- iBusAck  in  1  transaction complete.
- iBusErr  in  1  qualified by iBusAck.
- iBusRData  in  32  read data, valid with iBusAck.
- oRegOp  out  tRegOp (38)  load writeback; dv is a 1-cycle pulse.
- oErr  out  1  1-cycle error pulse.
- oErrCode  out  2  01 misaligned/illegal, 10 bus error, 11 timeout; holds its value until the next error.

## Operation
- States: eIdle, eReq.
- **eIdle, accept rule.** An op is accepted when iMemOpDv=1, exactly one of read/write is set, and iFlush=0. Ops with both or neither of read/write set are ignored silently.
- **Legality check on accept.**
  - opType[1:0]=11 is illegal.
  - Store with opType[2]=1 is illegal.
  - Half access with addr[0]≠0 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - Any illegal or misaligned op: oErr=1 next cycle, oErrCode=01, no bus activity, stay in eIdle.
- **Legal op.** Latch the bus fields and rdAddr, clear the timeout counter, go to eReq.
- **Store encoding:**
  - SB: BE=0001<<addr[1:0], WData={4{data[7:0]}}.
  - SH: BE=addr[1]?1100:0011, WData={2{data[15:0]}}.
  - SW: BE=1111, WData=data.
- **Loads:** oBusWe=0 and BE as for the store of the same size. Bus-side BE is informational for reads.
- **eReq:** oBusReq=1 with all bus outputs stable until iBusAck. The counter increments each cycle without ack.
- **Ack without error, read:** select the byte/half via addr[1:0] and extend.
  - opType 000 LB and 001 LH: sign-extend.
  - opType 010 LW: full word.
  - opType 100 LBU and 101 LHU: zero-extend.
  - Next cycle: oRegOp={dv, rdAddr, data}. dv is forced to 0 if rdAddr=0 or the op was flushed.
- **Ack without error, write:** no writeback.
- **Ack with iBusErr=1:** oErr, code 10, no writeback.
- **Timeout:** counter reaches pTimeout−1 without ack → drop oBusReq, oErr, code 11, return to eIdle.
- **After ack or timeout:** return to eIdle.
- **iFlush:**
  - In eIdle, it blocks acceptance.
  - In eReq, the bus handshake still completes, because a started transaction is never abandoned. A sticky flushed flag suppresses the writeback. Store data still commits.
- **Simultaneous iBusAck and timeout terminal count:** ack wins.

## Timing
- **Reset values:** state=eIdle; oBusReq=0, oBusWe=0, oBusAddr=0, oBusWData=0, oBusBe=0; oRegOp=0; oErr=0, oErrCode=00; counter=0. Async assertion drops oBusReq immediately, mid-transaction included.
- **oStall:** combinational, = (state==eReq). An op presented while oStall=1 is ignored and must be re-presented by upstream, which holds it.
- **Latency:** accept at cycle N; oBusReq from N+1. If ack at cycle A (A≥N+1), then oRegOp.dv/oErr at A+1, state eIdle at A+1. The next op can be accepted at A+1.
- **Zero-wait bus** (ack at N+1): 2-cycle load-to-writeback, one stall cycle.
- **Timeout:** oBusReq high for exactly pTimeout cycles.
- **Outputs:** oRegOp, oErr and oErrCode are registered; bus outputs come from registers.

## Structure
- Add to corePckg:
  - enum tMemCtrlState {eIdle, eReq}.
  - enum tMemSize {eByte=2'b00, eHalf=2'b01, eWord=2'b10}.
  - struct tDataBusReq {req, we, addr, wdata, be}.
  - enum tMemErr {eErrNone=2'b00, eErrAlign=2'b01, eErrBus=2'b10, eErrTimeout=2'b11}.
- Sub-module mem_load_align (combinational): inputs iBusRData, addr[1:0], opType; output the extended 32-bit load value. It is reused by any future cache path.

## Test plan
- **LB sign-extend:** LB addr=0x1003, rdAddr=5, ack after 2 wait cycles with rdata=0x80AA_BBCC → BE=1000, busAddr=0x1000, oRegOp={1,5,0xFFFF_FF80} one cycle after ack. Repeat as LBU → 0x0000_0080.
- **SH encoding:** SH addr=0x2002, data=0x1234_ABCD, zero-wait ack → BE=1100, WData=0xABCD_ABCD, oBusWe=1, no oRegOp.dv, oStall high exactly 1 cycle.
- **Misaligned word:** LW addr=0x3001 → oErr pulse next cycle, oErrCode=01, oBusReq never asserts. A back-to-back legal LW at addr=0x3004 is accepted the following cycle.
- **Timeout:** pTimeout=8, LW with ack never returned → oBusReq high exactly 8 cycles, then oErr with code 11, oStall drops. iBusErr with ack on the next load → code 10.
- **Flush during a load:** iFlush pulsed in the 2nd REQ cycle of LW rdAddr=7 → oBusReq held until ack, oRegOp.dv stays 0.
- **Reset mid-transaction:** iRst asserted in the 3rd REQ cycle → oBusReq low in the same cycle, all outputs at reset values. After release, a new SW completes normally.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the memory-stage controller: op/writeback structs,
// FSM/size/error enums and the store-side byte-lane encoding helpers.
package data_mem_ctrl_pkg;

    localparam int unsigned cXLEN = 32;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] data;
        logic [2:0]       opType;
        logic [4:0]       rdAddr;
    } tMemOp;

    typedef struct packed {
        logic             dv;
        logic [4:0]       rdAddr;
        logic [cXLEN-1:0] data;
    } tRegOp;

    typedef enum logic {
        eIdle,
        eReq
    } tMemCtrlState;

    typedef enum logic [1:0] {
        eByte = 2'b00,
        eHalf = 2'b01,
        eWord = 2'b10
    } tMemSize;

    typedef struct packed {
        logic             req;
        logic             we;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] wdata;
        logic [3:0]       be;
    } tDataBusReq;

    typedef enum logic [1:0] {
        eErrNone    = 2'b00,
        eErrAlign   = 2'b01,
        eErrBus     = 2'b10,
        eErrTimeout = 2'b11
    } tMemErr;

    function automatic logic [3:0] busBe(input logic [1:0] size, input logic [1:0] addrLo);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            eByte:   be = 4'b0001 << addrLo;
            eHalf:   be = addrLo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [cXLEN-1:0] busWData(input logic [1:0] size, input logic [cXLEN-1:0] data);
        logic [cXLEN-1:0] wdata;
        wdata = data;
        case (size)
            eByte:   wdata = {4{data[7:0]}};
            eHalf:   wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Combinational load aligner: picks the addressed byte/half out of a bus
// word and sign- or zero-extends it according to the load funct3.
module mem_load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [cXLEN-1:0] iBusRData,
    input  logic [1:0]       iAddr,
    input  logic [2:0]       iOpType,
    output logic [cXLEN-1:0] oData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = 8'h00;
        case (iAddr)
            2'd0: byteVal = iBusRData[7:0];
            2'd1: byteVal = iBusRData[15:8];
            2'd2: byteVal = iBusRData[23:16];
            default: byteVal = iBusRData[31:24];
        endcase
        halfVal = iAddr[1] ? iBusRData[31:16] : iBusRData[15:0];
    end

    always_comb begin
        oData = iBusRData;
        case (iOpType)
            3'b000: oData = {{24{byteVal[7]}}, byteVal};
            3'b001: oData = {{16{halfVal[15]}}, halfVal};
            3'b100: oData = {24'h000000, byteVal};
            3'b101: oData = {16'h0000, halfVal};
            default: oData = iBusRData;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage controller: sequences one load/store at a time onto a
// single-outstanding req/ack bus, with alignment checks and a req timeout.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned pTimeout = 64
) (
    input  logic             iClk,
    input  logic             iRst,
    input  tMemOp            iMemOp,
    input  logic             iMemOpDv,
    input  logic             iFlush,
    output logic             oStall,
    output logic             oBusReq,
    output logic             oBusWe,
    output logic [cXLEN-1:0] oBusAddr,
    output logic [cXLEN-1:0] oBusWData,
    output logic [3:0]       oBusBe,
    input  logic             iBusAck,
    input  logic             iBusErr,
    input  logic [cXLEN-1:0] iBusRData,
    output tRegOp            oRegOp,
    output logic             oErr,
    output logic [1:0]       oErrCode
);

    localparam int unsigned cCntW = (pTimeout > 2) ? $clog2(pTimeout) : 1;
    localparam logic [cCntW-1:0] cCntLast = cCntW'(pTimeout - 1);

    tMemCtrlState     state;
    tMemCtrlState     stateNext;
    tDataBusReq       bus;
    tMemErr           errCode;
    logic [cCntW-1:0] cnt;
    logic [1:0]       addrLo;
    logic [2:0]       opType;
    logic [4:0]       rdAddr;
    logic             flushed;

    logic             accept;
    logic             opIllegal;
    logic             timeoutHit;
    logic [1:0]       size;
    logic [cXLEN-1:0] loadData;

    mem_load_align u_load_align (
        .iBusRData (iBusRData),
        .iAddr     (addrLo),
        .iOpType   (opType),
        .oData     (loadData)
    );

    always_comb begin
        size       = iMemOp.opType[1:0];
        accept     = (state == eIdle) && iMemOpDv && (iMemOp.read ^ iMemOp.write) && !iFlush;
        opIllegal  = (size == 2'b11)
                  || (iMemOp.write && iMemOp.opType[2])
                  || (size == eHalf && iMemOp.addr[0])
                  || (size == eWord && iMemOp.addr[1:0] != 2'b00);
        timeoutHit = (state == eReq) && !iBusAck && (cnt == cCntLast);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= eIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            eIdle: if (accept && !opIllegal) stateNext = eReq;
            eReq:  if (iBusAck || timeoutHit) stateNext = eIdle;
            default: stateNext = eIdle;
        endcase
    end

    always_comb begin
        oStall    = (state == eReq);
        oBusReq   = bus.req;
        oBusWe    = bus.we;
        oBusAddr  = bus.addr;
        oBusWData = bus.wdata;
        oBusBe    = bus.be;
        oErrCode  = errCode;
    end

    // Ack is checked before the terminal count so a last-cycle ack still completes.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            bus     <= '0;
            cnt     <= '0;
            addrLo  <= '0;
            opType  <= '0;
            rdAddr  <= '0;
            flushed <= 1'b0;
            oRegOp  <= '0;
            oErr    <= 1'b0;
            errCode <= eErrNone;
        end else begin
            oErr      <= 1'b0;
            oRegOp.dv <= 1'b0;

            if (accept) begin
                if (opIllegal) begin
                    oErr    <= 1'b1;
                    errCode <= eErrAlign;
                end else begin
                    bus.req   <= 1'b1;
                    bus.we    <= iMemOp.write;
                    bus.addr  <= {iMemOp.addr[cXLEN-1:2], 2'b00};
                    bus.be    <= busBe(size, iMemOp.addr[1:0]);
                    bus.wdata <= busWData(size, iMemOp.data);
                    cnt       <= '0;
                    addrLo    <= iMemOp.addr[1:0];
                    opType    <= iMemOp.opType;
                    rdAddr    <= iMemOp.rdAddr;
                    flushed   <= 1'b0;
                end
            end

            if (state == eReq) begin
                if (iFlush) begin
                    flushed <= 1'b1;
                end
                if (iBusAck) begin
                    bus.req <= 1'b0;
                    if (iBusErr) begin
                        oErr    <= 1'b1;
                        errCode <= eErrBus;
                    end else if (!bus.we) begin
                        oRegOp <= '{dv:     (rdAddr != 5'd0) && !flushed && !iFlush,
                                    rdAddr: rdAddr,
                                    data:   loadData};
                    end
                end else if (timeoutHit) begin
                    bus.req <= 1'b0;
                    oErr    <= 1'b1;
                    errCode <= eErrTimeout;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (pTimeout=8).
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    tMemOp       iMemOp;
    logic        iMemOpDv = 1'b0;
    logic        iFlush = 1'b0;
    logic        oStall;
    logic        oBusReq;
    logic        oBusWe;
    logic [31:0] oBusAddr;
    logic [31:0] oBusWData;
    logic [3:0]  oBusBe;
    logic        iBusAck = 1'b0;
    logic        iBusErr = 1'b0;
    logic [31:0] iBusRData = '0;
    tRegOp       oRegOp;
    logic        oErr;
    logic [1:0]  oErrCode;

    int errors = 0;
    int checks = 0;
    int highs;

    data_mem_ctrl #(.pTimeout(8)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iMemOp    (iMemOp),
        .iMemOpDv  (iMemOpDv),
        .iFlush    (iFlush),
        .oStall    (oStall),
        .oBusReq   (oBusReq),
        .oBusWe    (oBusWe),
        .oBusAddr  (oBusAddr),
        .oBusWData (oBusWData),
        .oBusBe    (oBusBe),
        .iBusAck   (iBusAck),
        .iBusErr   (iBusErr),
        .iBusRData (iBusRData),
        .oRegOp    (oRegOp),
        .oErr      (oErr),
        .oErrCode  (oErrCode)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] op, input logic [4:0] r);
        iMemOp   = '{read: rd, write: wr, addr: a, data: d, opType: op, rdAddr: r};
        iMemOpDv = 1'b1;
        tick();
        iMemOpDv = 1'b0;
    endtask

    task automatic ack_after(input int waits, input logic [31:0] rdata, input logic err);
        repeat (waits) tick();
        iBusAck   = 1'b1;
        iBusErr   = err;
        iBusRData = rdata;
        tick();
        iBusAck   = 1'b0;
        iBusErr   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        iMemOp = '0;
        #2;
        chk("rst_ctrl", 64'({oBusReq, oBusWe, oBusBe, oStall}), 64'(0));
        chk("rst_addr", 64'(oBusAddr), 64'(0));
        chk("rst_wdata", 64'(oBusWData), 64'(0));
        chk("rst_regop", 64'(oRegOp), 64'(0));
        chk("rst_err", 64'({oErr, oErrCode}), 64'(0));
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        tick();

        // LB sign-extend, two wait cycles
        present(1'b1, 1'b0, 32'h0000_1003, 32'h0, 3'b000, 5'd5);
        chk("lb_req", 64'({oBusReq, oBusWe, oStall}), 64'(3'b101));
        chk("lb_be", 64'(oBusBe), 64'(4'b1000));
        chk("lb_addr", 64'(oBusAddr), 64'(32'h0000_1000));
        ack_after(2, 32'h80AA_BBCC, 1'b0);
        chk("lb_regop", 64'(oRegOp), 64'({1'b1, 5'd5, 32'hFFFF_FF80}));
        chk("lb_idle", 64'({oBusReq, oStall}), 64'(0));
        tick();
        chk("lb_dv_pulse", 64'(oRegOp.dv), 64'(0));

        // LBU same address
        present(1'b1, 1'b0, 32'h0000_1003, 32'h0, 3'b100, 5'd5);
        ack_after(2, 32'h80AA_BBCC, 1'b0);
        chk("lbu_regop", 64'(oRegOp), 64'({1'b1, 5'd5, 32'h0000_0080}));

        // SH upper half, zero-wait
        present(1'b0, 1'b1, 32'h0000_2002, 32'h1234_ABCD, 3'b001, 5'd0);
        chk("sh_be", 64'(oBusBe), 64'(4'b1100));
        chk("sh_wdata", 64'(oBusWData), 64'(32'hABCD_ABCD));
        chk("sh_we_stall", 64'({oBusWe, oStall, oBusReq}), 64'(3'b111));
        ack_after(0, 32'h0, 1'b0);
        chk("sh_done", 64'({oStall, oBusReq, oRegOp.dv, oErr}), 64'(0));

        // SB byte lane 1
        present(1'b0, 1'b1, 32'h0000_8001, 32'h0000_00A5, 3'b000, 5'd0);
        chk("sb_be", 64'(oBusBe), 64'(4'b0010));
        chk("sb_wdata", 64'(oBusWData), 64'(32'hA5A5_A5A5));
        ack_after(0, 32'h0, 1'b0);

        // LH / LHU
        present(1'b1, 1'b0, 32'h0000_8000, 32'h0, 3'b001, 5'd9);
        chk("lh_be", 64'(oBusBe), 64'(4'b0011));
        ack_after(1, 32'h0000_F00F, 1'b0);
        chk("lh_regop", 64'(oRegOp), 64'({1'b1, 5'd9, 32'hFFFF_F00F}));
        present(1'b1, 1'b0, 32'h0000_8002, 32'h0, 3'b101, 5'd10);
        ack_after(0, 32'h8765_4321, 1'b0);
        chk("lhu_regop", 64'(oRegOp), 64'({1'b1, 5'd10, 32'h0000_8765}));

        // Misaligned LW then back-to-back legal LW
        present(1'b1, 1'b0, 32'h0000_3001, 32'h0, 3'b010, 5'd1);
        chk("mis_err", 64'({oErr, oErrCode}), 64'(3'b101));
        chk("mis_noreq", 64'({oBusReq, oStall}), 64'(0));
        present(1'b1, 1'b0, 32'h0000_3004, 32'h0, 3'b010, 5'd2);
        chk("b2b_req", 64'({oBusReq, oErr}), 64'(2'b10));
        chk("b2b_addr", 64'(oBusAddr), 64'(32'h0000_3004));
        ack_after(0, 32'hDEAD_BEEF, 1'b0);
        chk("b2b_regop", 64'(oRegOp), 64'({1'b1, 5'd2, 32'hDEAD_BEEF}));
        chk("errcode_hold", 64'({oErr, oErrCode}), 64'(3'b001));

        // Illegal ops and ignored ops
        present(1'b0, 1'b1, 32'h0000_0100, 32'h0, 3'b100, 5'd0);
        chk("ill_store", 64'({oErr, oErrCode, oBusReq}), 64'(4'b1010));
        present(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b011, 5'd3);
        chk("ill_size", 64'({oErr, oErrCode, oBusReq}), 64'(4'b1010));
        present(1'b1, 1'b1, 32'h0000_0100, 32'h0, 3'b010, 5'd3);
        chk("rw_both_ignored", 64'({oErr, oBusReq, oStall}), 64'(0));
        iFlush = 1'b1;
        present(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 5'd3);
        iFlush = 1'b0;
        chk("flush_blocks", 64'({oErr, oBusReq, oStall}), 64'(0));

        // rdAddr=0 suppresses writeback
        present(1'b1, 1'b0, 32'h0000_6100, 32'h0, 3'b010, 5'd0);
        ack_after(0, 32'h0000_0055, 1'b0);
        chk("rd0_nodv", 64'({oRegOp.dv, oErr}), 64'(0));

        // Timeout: req high exactly 8 cycles
        present(1'b1, 1'b0, 32'h0000_4000, 32'h0, 3'b010, 5'd3);
        highs = 0;
        while (oBusReq === 1'b1 && highs < 20) begin
            highs++;
            tick();
        end
        chk("to_req_cycles", 64'(highs), 64'(8));
        chk("to_err", 64'({oErr, oErrCode, oStall}), 64'(4'b1110));
        tick();
        chk("to_err_pulse", 64'(oErr), 64'(0));

        // Bus error on ack
        present(1'b1, 1'b0, 32'h0000_5000, 32'h0, 3'b010, 5'd4);
        ack_after(0, 32'h1234_5678, 1'b1);
        chk("buserr", 64'({oErr, oErrCode, oRegOp.dv}), 64'(4'b1100));

        // Flush in 2nd REQ cycle
        present(1'b1, 1'b0, 32'h0000_6000, 32'h0, 3'b010, 5'd7);
        tick();
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
        chk("flush_req_held", 64'({oBusReq, oStall}), 64'(2'b11));
        ack_after(0, 32'h1111_1111, 1'b0);
        chk("flush_nodv", 64'({oRegOp.dv, oBusReq, oStall}), 64'(0));

        // Async reset in 3rd REQ cycle
        present(1'b0, 1'b1, 32'h0000_7000, 32'hCAFE_F00D, 3'b010, 5'd0);
        tick();
        tick();
        chk("pre_rst_req", 64'(oBusReq), 64'(1));
        #2;
        iRst = 1'b1;
        #1;
        chk("mid_rst_ctrl", 64'({oBusReq, oBusWe, oBusBe, oStall}), 64'(0));
        chk("mid_rst_data", 64'({oBusAddr, oBusWData}), 64'(0));
        chk("mid_rst_out", 64'({oRegOp, oErr, oErrCode}), 64'(0));
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        tick();
        present(1'b0, 1'b1, 32'h0000_7004, 32'h0BAD_CAFE, 3'b010, 5'd0);
        chk("sw_be", 64'({oBusBe, oBusWe, oBusReq}), 64'(6'b111111));
        chk("sw_bus", 64'({oBusAddr, oBusWData}), 64'({32'h0000_7004, 32'h0BAD_CAFE}));
        ack_after(0, 32'h0, 1'b0);
        chk("sw_done", 64'({oBusReq, oStall, oErr, oRegOp.dv}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
